// File: rtl/mult_pkg.sv
// mult_pkg: shared types and defaults for the multiplier arbiter.
//   state_t     - arbiter FSM states
//   DEF_WIDTH   - default operand width
//   DEF_TIMEOUT - default watchdog limit for a DEF_WIDTH multiplier
//   idx_w()     - width of an index into n requesters (at least 1 bit)
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_TIMEOUT = 2*DEF_WIDTH + 4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req   - request vector
//   ptr   - highest-priority requester for this decision
//   grant - one-hot winner (zero if no request)
//   idx   - binary index of the winner
//   any   - at least one request present
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int j;

  // Walk from the farthest offset back to ptr so the closest requester
  // at or after ptr is the last (winning) assignment.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |req;
    j     = 0;
    for (int k = NREQ-1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one sequential multiplier among NREQ requesters.
//   clk, reset            - clock, synchronous active-high reset
//   req_valid/ready/a/b   - per-requester operation request (ready one-hot)
//   resp_valid/ready      - per-requester result handshake (valid one-hot)
//   resp_product/resp_err - shared result bus, err flags a watchdog timeout
//   mul_start/a/b         - start pulse and operands to the multiplier
//   mul_done/product      - completion pulse and result from the multiplier
//   busy                  - FSM is not IDLE
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 2*WIDTH + 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [2*WIDTH-1:0]    resp_product,
  output logic                  resp_err,
  output logic                  mul_start,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic                  mul_done,
  input  logic [2*WIDTH-1:0]    mul_product,
  output logic                  busy
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t               state, state_nxt;
  logic [IW-1:0]        rr_ptr, owner, gnt_idx;
  logic [NREQ-1:0]      gnt;
  logic                 gnt_any;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     op_a, op_b;
  logic [2*WIDTH-1:0]   result;
  logic                 err;
  logic                 rst_d;
  logic                 accept, owner_rdy, timeout_hit;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  // rst_d keeps the first cycle after reset quiet: no grant, outputs all 0.
  assign accept      = (state == IDLE) && gnt_any && !rst_d && !reset;
  assign owner_rdy   = resp_ready[owner];
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    rst_d <= reset;
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      cnt    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: if (accept) begin
          owner <= gnt_idx;
          op_a  <= req_a[gnt_idx*WIDTH +: WIDTH];
          op_b  <= req_b[gnt_idx*WIDTH +: WIDTH];
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          if (mul_done) begin
            result <= mul_product;
            err    <= 1'b0;
          end else if (timeout_hit) begin
            result <= '0;
            err    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: if (owner_rdy)
          rr_ptr <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt    = state;
    req_ready    = '0;
    resp_valid   = '0;
    resp_product = '0;
    resp_err     = 1'b0;
    mul_start    = 1'b0;
    mul_a        = '0;
    mul_b        = '0;
    busy         = 1'b0;

    unique case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (mul_done || timeout_hit) state_nxt = RESP;
      RESP:    if (owner_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Outputs are forced low while reset is asserted, even mid-transaction.
    if (!reset) begin
      if (accept) req_ready = gnt;
      if (state == RESP) begin
        resp_valid[owner] = 1'b1;
        resp_product      = result;
        resp_err          = err;
      end
      mul_start = (state == ISSUE);
      mul_a     = op_a;
      mul_b     = op_b;
      busy      = (state != IDLE);
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: scoreboard bench for mult_arbiter with a behavioural
// sequential multiplier whose latency is set per test (0 = never done).
module tb_mult_arbiter;

  localparam int W  = 8;
  localparam int N  = 2;
  localparam int TO = 2*W + 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid, req_ready, resp_valid, resp_ready;
  logic [N*W-1:0]   req_a, req_b;
  logic [2*W-1:0]   resp_product;
  logic             resp_err, mul_start, busy;
  logic [W-1:0]     mul_a, mul_b;
  logic             mul_done = 1'b0;
  logic [2*W-1:0]   mul_product = '0;

  always #5 clk = ~clk;

  mult_arbiter #(.WIDTH(W), .NREQ(N), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_product (resp_product),
    .resp_err     (resp_err),
    .mul_start    (mul_start),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_done     (mul_done),
    .mul_product  (mul_product),
    .busy         (busy)
  );

  typedef struct {
    int             idx;
    logic [2*W-1:0] prod;
    logic           err;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   nerr = 0;

  // Multiplier model: done pulse mdelay cycles after the start cycle.
  int             mdelay = 10;
  int             mcnt   = 0;
  logic           mbusy  = 1'b0;
  logic [2*W-1:0] mres   = '0;

  always begin
    @(posedge clk); #1;
    mul_done = 1'b0;
    if (mbusy) begin
      mcnt--;
      if (mcnt == 0) begin
        mul_done    = 1'b1;
        mul_product = mres;
        mbusy       = 1'b0;
      end
    end
    if (mul_start && mdelay > 0) begin
      mbusy = 1'b1;
      mcnt  = mdelay;
      mres  = (2*W)'(mul_a) * (2*W)'(mul_b);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    return (2*W)'(a) * (2*W)'(b);
  endfunction

  function automatic logic [38:0] all_outs();
    return {req_ready, resp_valid, resp_product, resp_err, mul_start, mul_a, mul_b, busy};
  endfunction

  task automatic wait_grant(output logic [N-1:0] g, output int waited);
    waited = 0;
    #1;
    while (req_ready == '0 && waited < 50) begin cyc(); #1; waited++; end
    g = req_ready;
  endtask

  // Waits for a response, checks it against the scoreboard head, holds
  // resp_ready low for 'hold' cycles (non-owners ready) then handshakes.
  task automatic collect(input int hold);
    exp_t           e;
    int             w;
    logic [N-1:0]   v0;
    logic [2*W-1:0] p0;
    logic           er0;
    w = 0;
    while (resp_valid == '0 && w < 200) begin cyc(); w++; end
    nchk++;
    if (resp_valid == '0 || sb.size() == 0) begin
      nerr++;
      $display("FAIL resp_wait: resp_valid=%b queued=%0d, want a response", resp_valid, sb.size());
      return;
    end
    e = sb.pop_front();
    nchk++;
    if (resp_valid !== N'(1 << e.idx)) begin
      nerr++; $display("FAIL resp_owner: got %b want %b", resp_valid, N'(1 << e.idx));
    end
    nchk++;
    if (resp_product !== e.prod) begin
      nerr++; $display("FAIL resp_product: got %0d want %0d", resp_product, e.prod);
    end
    nchk++;
    if (resp_err !== e.err) begin
      nerr++; $display("FAIL resp_err: got %b want %b", resp_err, e.err);
    end
    v0 = resp_valid; p0 = resp_product; er0 = resp_err;
    for (int i = 0; i < hold; i++) begin
      resp_ready = ~v0;
      cyc();
      nchk++;
      if (resp_valid !== v0 || resp_product !== p0 || resp_err !== er0) begin
        nerr++;
        $display("FAIL resp_hold: got v=%b p=%0d e=%b want v=%b p=%0d e=%b",
                 resp_valid, resp_product, resp_err, v0, p0, er0);
      end
      nchk++;
      if (req_ready !== '0) begin
        nerr++; $display("FAIL hold_req_ready: got %b want 0", req_ready);
      end
    end
    resp_ready = v0;
    cyc();
    resp_ready = '0;
    nchk++;
    if (resp_valid !== '0 || busy !== 1'b0) begin
      nerr++; $display("FAIL resp_release: got v=%b busy=%b want 0/0", resp_valid, busy);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    req_valid  = '1;
    resp_ready = '1;
    set_ops(0, 8'h11, 8'h22);
    set_ops(1, 8'h33, 8'h44);
    cyc(2);
    nchk++;
    if (all_outs() !== '0) begin
      nerr++; $display("FAIL reset_high_outs: got %h want 0", all_outs());
    end
    reset = 1'b0;
    #1;
    nchk++;
    if (all_outs() !== '0) begin
      nerr++; $display("FAIL reset_after_outs: got %h want 0", all_outs());
    end
    req_valid  = '0;
    resp_ready = '0;
    cyc();
  endtask

  task automatic test_contention();
    logic [N-1:0] g;
    int           w;
    mdelay = 4;
    set_ops(0, 8'd3, 8'd5);
    set_ops(1, 8'd4, 8'd4);
    req_valid = 2'b11;
    wait_grant(g, w);
    nchk++;
    if (g !== 2'b01) begin nerr++; $display("FAIL cont_first_grant: got %b want 01", g); end
    sb.push_back('{0, ref_mul(8'd3, 8'd5), 1'b0});
    cyc();
    req_valid = 2'b10;
    #1;
    nchk++;
    if (req_ready !== '0 || mul_start !== 1'b1) begin
      nerr++; $display("FAIL cont_issue: got ready=%b start=%b want 00/1", req_ready, mul_start);
    end
    collect(0);
    wait_grant(g, w);
    nchk++;
    if (g !== 2'b10 || w !== 0) begin
      nerr++; $display("FAIL cont_second_grant: got %b after %0d want 10 after 0", g, w);
    end
    sb.push_back('{1, ref_mul(8'd4, 8'd4), 1'b0});
    cyc();
    req_valid = '0;
    collect(0);
    // Pointer must be back at 0: a fresh tie goes to requester 0.
    set_ops(0, 8'd10, 8'd20);
    req_valid = 2'b11;
    wait_grant(g, w);
    nchk++;
    if (g !== 2'b01) begin nerr++; $display("FAIL cont_ptr_wrap: got %b want 01", g); end
    sb.push_back('{0, ref_mul(8'd10, 8'd20), 1'b0});
    cyc();
    req_valid = '0;
    collect(0);
  endtask

  task automatic test_single();
    logic [N-1:0] g;
    int           w, lat;
    mdelay = 10;
    set_ops(0, 8'd7, 8'd6);
    req_valid = 2'b01;
    wait_grant(g, w);
    nchk++;
    if (g !== 2'b01) begin nerr++; $display("FAIL single_grant: got %b want 01", g); end
    sb.push_back('{0, ref_mul(8'd7, 8'd6), 1'b0});
    cyc();
    req_valid = '0;
    nchk++;
    if (mul_start !== 1'b1 || mul_a !== 8'd7 || mul_b !== 8'd6) begin
      nerr++; $display("FAIL single_start: got start=%b a=%0d b=%0d want 1/7/6", mul_start, mul_a, mul_b);
    end
    cyc();
    nchk++;
    if (mul_start !== 1'b0 || busy !== 1'b1 || mul_a !== 8'd7 || mul_b !== 8'd6) begin
      nerr++; $display("FAIL single_wait: got start=%b busy=%b a=%0d b=%0d want 0/1/7/6",
                       mul_start, busy, mul_a, mul_b);
    end
    lat = 2;
    while (resp_valid == '0 && lat < 100) begin cyc(); lat++; end
    nchk++;
    if (lat !== 12) begin nerr++; $display("FAIL single_latency: got %0d want 12", lat); end
    collect(0);
  endtask

  task automatic test_backpressure();
    logic [N-1:0] g;
    int           w;
    mdelay = 3;
    set_ops(1, 8'd255, 8'd255);
    req_valid = 2'b10;
    wait_grant(g, w);
    nchk++;
    if (g !== 2'b10) begin nerr++; $display("FAIL bp_grant: got %b want 10", g); end
    sb.push_back('{1, ref_mul(8'd255, 8'd255), 1'b0});
    cyc();
    set_ops(0, 8'd12, 8'd11);
    req_valid = 2'b01;
    #1;
    nchk++;
    if (req_ready !== '0) begin nerr++; $display("FAIL bp_busy_ready: got %b want 00", req_ready); end
    collect(5);
    wait_grant(g, w);
    nchk++;
    if (g !== 2'b01 || w !== 0) begin
      nerr++; $display("FAIL bp_next_grant: got %b after %0d want 01 after 0", g, w);
    end
    sb.push_back('{0, ref_mul(8'd12, 8'd11), 1'b0});
    cyc();
    req_valid = '0;
    collect(0);
  endtask

  task automatic test_timeout();
    logic [N-1:0] g;
    int           w, lat;
    mdelay = 0;
    set_ops(0, 8'd9, 8'd9);
    req_valid = 2'b01;
    wait_grant(g, w);
    nchk++;
    if (g !== 2'b01) begin nerr++; $display("FAIL to_grant: got %b want 01", g); end
    sb.push_back('{0, '0, 1'b1});
    cyc();
    req_valid = '0;
    lat = 1;
    while (resp_valid == '0 && lat < 100) begin cyc(); lat++; end
    nchk++;
    if (lat !== TO + 2) begin nerr++; $display("FAIL to_latency: got %0d want %0d", lat, TO + 2); end
    collect(2);
    mdelay = 10;
  endtask

  task automatic test_reset_in_wait();
    logic [N-1:0] g;
    int           w;
    logic         bad;
    mdelay = 10;
    set_ops(1, 8'd2, 8'd3);
    req_valid = 2'b10;
    wait_grant(g, w);
    nchk++;
    if (g !== 2'b10) begin nerr++; $display("FAIL rw_grant: got %b want 10", g); end
    cyc();
    req_valid = '0;
    cyc(2);
    nchk++;
    if (busy !== 1'b1) begin nerr++; $display("FAIL rw_busy: got %b want 1", busy); end
    reset = 1'b1;
    #1;
    nchk++;
    if (all_outs() !== '0) begin nerr++; $display("FAIL rw_reset_outs: got %h want 0", all_outs()); end
    cyc();
    reset = 1'b0;
    #1;
    nchk++;
    if (all_outs() !== '0) begin nerr++; $display("FAIL rw_after_outs: got %h want 0", all_outs()); end
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (resp_valid !== '0 || busy !== 1'b0) bad = 1'b1;
    end
    nchk++;
    if (bad !== 1'b0) begin nerr++; $display("FAIL rw_stray_done: got activity=%b want 0", bad); end
  endtask

  task automatic test_fairness();
    logic [N-1:0] g;
    int           w, ptr;
    logic [W-1:0] a [N];
    logic [W-1:0] b [N];
    ptr = 0;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++) begin
        a[i] = W'($urandom);
        b[i] = W'($urandom);
        set_ops(i, a[i], b[i]);
      end
      req_valid = '1;
      wait_grant(g, w);
      nchk++;
      if (g !== N'(1 << ptr) || w !== 0) begin
        nerr++; $display("FAIL fair_grant_%0d: got %b after %0d want %b after 0", t, g, w, N'(1 << ptr));
      end
      sb.push_back('{ptr, ref_mul(a[ptr], b[ptr]), 1'b0});
      mdelay = $urandom_range(1, 6);
      cyc();
      collect($urandom_range(0, 2));
      ptr = (ptr + 1) % N;
    end
    req_valid = '0;
  endtask

  initial begin
    req_valid  = '0;
    resp_ready = '0;
    req_a      = '0;
    req_b      = '0;
    reset      = 1'b1;
    test_reset();
    test_contention();
    test_single();
    test_backpressure();
    test_timeout();
    test_reset_in_wait();
    test_fairness();
    cyc(3);
    nchk++;
    if (sb.size() !== 0) begin nerr++; $display("FAIL sb_empty: got %0d pending want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
